// File: rtl/piso_tx_pkg.sv
// Shared definitions for the piso_tx serialiser.
// Optional feature macro: PISO_TX_PARITY_EN (adds the even-parity PAR cycle).
package piso_tx_pkg;

  localparam int unsigned PISO_TX_WIDTH = 8;

  typedef enum logic [1:0] {
`ifdef PISO_TX_PARITY_EN
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
`else
    IDLE  = 2'd0,
    SHIFT = 2'd1
`endif
  } piso_state_t;

endpackage

// File: rtl/piso_shreg.sv
// WIDTH-bit loadable left-shift register; zeros enter at the LSB.
// Reset has priority over load, load has priority over shift.
module piso_shreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LD,
  input  logic             SH,
  input  logic [WIDTH-1:0] D,
  output logic             MSB
);

  logic [WIDTH-1:0] q;

  // register update: reset, parallel load, or shift left by one
  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= '0;
    end else if (LD) begin
      q <= D;
    end else if (SH) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign MSB = q[WIDTH-1];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, one bit per CLK.
// Optional feature macro: PISO_TX_PARITY_EN (one even-parity bit after the data).
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_TX_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             READY,
  output logic             SOUT,
  output logic             FRAME,
  output logic             DONE
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  piso_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic             ld, sh;
  logic [WIDTH-1:0] ld_data;
  logic             load_acc;
`ifdef PISO_TX_PARITY_EN
  logic             par_q;
`endif

  assign load_acc = (state_q == IDLE) && LOAD;

  // next-state and shift-register control
  // The parity bit is reloaded into the MSB on the last data edge, so SOUT
  // stays a direct flop output in every state, including PAR.
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    sh      = 1'b0;
    ld_data = DIN;
    case (state_q)
      IDLE: begin
        if (LOAD) begin
          ld      = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
`ifdef PISO_TX_PARITY_EN
          ld      = 1'b1;
          ld_data = {par_q, {(WIDTH-1){1'b0}}};
          state_d = PAR;
`else
          sh      = 1'b1;
          state_d = IDLE;
`endif
        end else begin
          sh = 1'b1;
        end
      end
`ifdef PISO_TX_PARITY_EN
      PAR: begin
        sh      = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // state, bit counter, done pulse and parity registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= (state_q != IDLE) && (state_d == IDLE);
      if (load_acc) begin
        cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        cnt_q <= cnt_q + CW'(1);
      end
`ifdef PISO_TX_PARITY_EN
      if (load_acc) begin
        par_q <= ^DIN;
      end
`endif
    end
  end

  piso_shreg #(.WIDTH(WIDTH)) u_shreg (
    .CLK (CLK),
    .RST (RST),
    .LD  (ld),
    .SH  (sh),
    .D   (ld_data),
    .MSB (SOUT)
  );

  assign READY = (state_q == IDLE);
  assign FRAME = (state_q != IDLE);
  assign DONE  = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx (WIDTH=8), both with and without
// PISO_TX_PARITY_EN.
module tb_piso_tx;

  localparam int unsigned W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic         CLK;
  logic         RST;
  logic [W-1:0] DIN;
  logic         LOAD;
  logic         READY, SOUT, FRAME, DONE;

  piso_tx #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .DIN   (DIN),
    .LOAD  (LOAD),
    .READY (READY),
    .SOUT  (SOUT),
    .FRAME (FRAME),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of per-cycle expected outputs for a whole frame
  typedef struct packed {
    logic sout;
    logic frame;
    logic done;
    logic ready;
  } exp_t;

  localparam exp_t IDLE_E = '{sout: 1'b0, frame: 1'b0, done: 1'b0, ready: 1'b1};

  exp_t cur;
  exp_t fq[$];
  bit   mvalid = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      fq.delete();
      cur = IDLE_E;
    end else begin
      if (cur.ready && LOAD) begin
        fq.delete();
        for (int i = W - 1; i >= 0; i--)
          fq.push_back('{sout: DIN[i], frame: 1'b1, done: 1'b0, ready: 1'b0});
        if (P == 1)
          fq.push_back('{sout: ^DIN, frame: 1'b1, done: 1'b0, ready: 1'b0});
        fq.push_back('{sout: 1'b0, frame: 1'b0, done: 1'b1, ready: 1'b1});
      end
      if (fq.size() > 0) cur = fq.pop_front();
      else               cur = IDLE_E;
    end
    mvalid = 1'b1;
  end

  // every-cycle comparison against the model
  always @(negedge CLK) begin
    if (mvalid) begin
      check("m_sout",  SOUT,  cur.sout);
      check("m_frame", FRAME, cur.frame);
      check("m_done",  DONE,  cur.done);
      check("m_ready", READY, cur.ready);
    end
  end

  logic s[0:31], f[0:31], d[0:31], r[0:31];

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic record(input int k);
    s[k] = SOUT; f[k] = FRAME; d[k] = DONE; r[k] = READY;
  endtask

  // load word w at edge 0, scramble DIN during the frame, record cycles 1..12
  task automatic capture(input logic [W-1:0] w);
    LOAD = 1'b1; DIN = w;
    for (int k = 1; k <= 12; k++) begin
      step();
      LOAD = 1'b0;
      DIN  = W'($urandom);
      record(k);
    end
  endtask

  logic [W-1:0] word;
  int           idle_cnt;
  bit           flag;
  int           dc;

  initial begin
    RST = 1'b1; LOAD = 1'b0; DIN = '0;
    repeat (2) step();
    RST = 1'b0;
    step();
    check("rst_ready", READY, 1);
    check("rst_sout",  SOUT,  0);
    check("rst_frame", FRAME, 0);
    check("rst_done",  DONE,  0);

    // A5 frame
    capture(8'hA5);
    for (int k = 1; k <= 8; k++) word[8 - k] = s[k];
    check("a5_bits", word, 8'hA5);
    flag = 1'b1;
    for (int k = 1; k <= 8; k++) if (f[k] !== 1'b1) flag = 1'b0;
    check("a5_frame", flag, 1);
    if (P == 1) begin
      check("a5_par_sout",  s[9],  0);
      check("a5_par_frame", f[9],  1);
      check("a5_done9",     d[9],  0);
      check("a5_done10",    d[10], 1);
    end else begin
      check("a5_frame9", f[9],  0);
      check("a5_done9",  d[9],  1);
      check("a5_done10", d[10], 0);
    end

    // 01 frame
    capture(8'h01);
    for (int k = 1; k <= 8; k++) word[8 - k] = s[k];
    check("w01_bits", word, 8'h01);
    if (P == 1) check("w01_par", s[9], 1);
    else        check("w01_done", d[9], 1);
    repeat (2) step();

    // back-to-back: LOAD held high, FF accepted only in the DONE cycle
    dc = 9 + P;
    LOAD = 1'b1; DIN = 8'hA5;
    step();
    record(1);
    DIN = 8'hFF;
    for (int k = 2; k <= dc + 10; k++) begin
      step();
      record(k);
      if (k == dc + 1) LOAD = 1'b0;
    end
    check("b2b_done",  d[dc], 1);
    check("b2b_gap_s", s[dc], 0);
    check("b2b_gap_f", f[dc], 0);
    for (int k = 1; k <= 8; k++) word[8 - k] = s[dc + k];
    check("b2b_ff_bits", word, 8'hFF);
    idle_cnt = 0;
    for (int k = 1; k <= dc + 8; k++) if (f[k] === 1'b0) idle_cnt++;
    check("b2b_idle_cycles", idle_cnt, 1);
    repeat (4) step();

    // reset in cycle 4 of the A5 frame
    LOAD = 1'b1; DIN = 8'hA5;
    step();
    LOAD = 1'b0;
    repeat (3) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("abort_sout",  SOUT,  0);
    check("abort_frame", FRAME, 0);
    check("abort_ready", READY, 1);
    flag = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (DONE !== 1'b0) flag = 1'b1;
      step();
    end
    check("abort_no_done", flag, 0);

    // reset and load together
    RST = 1'b1; LOAD = 1'b1; DIN = 8'hFF;
    step();
    RST = 1'b0; LOAD = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (SOUT !== 1'b0 || READY !== 1'b1 || FRAME !== 1'b0) flag = 1'b1;
      step();
    end
    check("rstload_idle", flag, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      RST  = ($urandom_range(0, 63) == 0);
      LOAD = $urandom_range(0, 1) == 1;
      DIN  = W'($urandom);
      step();
    end
    RST = 1'b0; LOAD = 1'b0;
    repeat (12) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
